// File: rtl/opfetch_pkg.sv
// Shared widths and FSM state encoding for the operand fetch controller.
package opfetch_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned OP_W_DEF   = 3;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    PRESENT = 2'd3
  } state_e;

endpackage

// File: rtl/operand_fetch_ctrl.sv
// Sequences one ALU operation: issues operand addresses, waits out the
// synchronous memory read, captures both operands and presents them to the ALU.
module operand_fetch_ctrl #(
  parameter int unsigned ADDR_W = opfetch_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = opfetch_pkg::DATA_W_DEF,
  parameter int unsigned OP_W   = opfetch_pkg::OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr1,
  input  logic [ADDR_W-1:0] cmd_addr2,
  output logic [ADDR_W-1:0] operand1_addr,
  output logic [ADDR_W-1:0] operand2_addr,
  input  logic [DATA_W-1:0] operand1_value,
  input  logic [DATA_W-1:0] operand2_value,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              busy,
  output logic [7:0]        op_count
);

  import opfetch_pkg::*;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr1_q, addr1_d;
  logic [ADDR_W-1:0]   addr2_q, addr2_d;
  logic [OP_W-1:0]     op_lat_q, op_lat_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic                alu_valid_q, alu_valid_d;
  logic [CNT_W-1:0]    op_count_q, op_count_d;

  // Next-state and register-update decode
  always_comb begin
    state_d     = state_q;
    addr1_d     = addr1_q;
    addr2_d     = addr2_q;
    op_lat_d    = op_lat_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_valid_d = alu_valid_q;
    op_count_d  = op_count_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_lat_d = cmd_op;
          addr1_d  = cmd_addr1;
          addr2_d  = cmd_addr2;
          state_d  = READ;
        end
      end
      READ: begin
        // memories register the addressed words on this edge
        state_d = CAPTURE;
      end
      CAPTURE: begin
        alu_a_d     = operand1_value;
        alu_b_d     = operand2_value;
        alu_op_d    = op_lat_q;
        alu_valid_d = 1'b1;
        state_d     = PRESENT;
      end
      PRESENT: begin
        if (alu_valid_q && alu_ready) begin
          alu_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr1_q     <= '0;
      addr2_q     <= '0;
      op_lat_q    <= '0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr1_q     <= addr1_d;
      addr2_q     <= addr2_d;
      op_lat_q    <= op_lat_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_valid_q <= alu_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign operand1_addr = addr1_q;
  assign operand2_addr = addr2_q;
  assign alu_valid     = alu_valid_q;
  assign alu_op        = alu_op_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign op_count      = op_count_q;

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Bench for operand_fetch_ctrl with two synchronous-read operand memories beside it.
module tb_operand_fetch_ctrl;

  import opfetch_pkg::*;

  localparam int unsigned AW = ADDR_W_DEF;
  localparam int unsigned DW = DATA_W_DEF;
  localparam int unsigned OW = OP_W_DEF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [OW-1:0] cmd_op;
  logic [AW-1:0] cmd_addr1;
  logic [AW-1:0] cmd_addr2;
  logic [AW-1:0] operand1_addr;
  logic [AW-1:0] operand2_addr;
  logic [DW-1:0] operand1_value;
  logic [DW-1:0] operand2_value;
  logic          alu_valid;
  logic          alu_ready;
  logic [OW-1:0] alu_op;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic          busy;
  logic [7:0]    op_count;

  logic [DW-1:0] mem1 [16];
  logic [DW-1:0] mem2 [16];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int exp_count = 0;
  int hs_cycle  = 0;

  always #5 clk = ~clk;

  operand_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_addr1      (cmd_addr1),
    .cmd_addr2      (cmd_addr2),
    .operand1_addr  (operand1_addr),
    .operand2_addr  (operand2_addr),
    .operand1_value (operand1_value),
    .operand2_value (operand2_value),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_op         (alu_op),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .busy           (busy),
    .op_count       (op_count)
  );

  // Operand memories: one-cycle synchronous read
  always_ff @(posedge clk) begin
    operand1_value <= mem1[operand1_addr];
    operand2_value <= mem2[operand2_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // One complete operation; expectations come from the memory arrays and a modular count.
  task automatic do_op(input logic [OW-1:0] op, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input int stall, input bit hold_valid,
                       output logic [DW-1:0] got_a, output logic [DW-1:0] got_b);
    logic [DW-1:0] e_a;
    logic [DW-1:0] e_b;
    int n;
    e_a = mem1[a1];
    e_b = mem2[a2];
    cmd_op    = op;
    cmd_addr1 = a1;
    cmd_addr2 = a2;
    cmd_valid = 1'b1;
    alu_ready = (stall == 0);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL op_idle_ready got %b want 1", cmd_ready);
    end
    tick();
    if (!hold_valid) cmd_valid = 1'b0;
    checks++;
    if ({busy, cmd_ready, operand1_addr, operand2_addr} !== {1'b1, 1'b0, a1, a2}) begin
      errors++;
      $display("FAIL op_accept got busy=%b rdy=%b a1=%h a2=%h want 1 0 %h %h",
               busy, cmd_ready, operand1_addr, operand2_addr, a1, a2);
    end
    n = 0;
    while (alu_valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL op_latency got %0d cycles want 2", n);
    end
    got_a = alu_a;
    got_b = alu_b;
    checks++;
    if ({alu_op, alu_a, alu_b} !== {op, e_a, e_b}) begin
      errors++;
      $display("FAIL op_data got op=%h a=%h b=%h want op=%h a=%h b=%h",
               alu_op, alu_a, alu_b, op, e_a, e_b);
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      checks++;
      if ({alu_valid, cmd_ready, alu_op, alu_a, alu_b} !== {1'b1, 1'b0, op, e_a, e_b}) begin
        errors++;
        $display("FAIL op_stall cyc%0d got v=%b rdy=%b op=%h a=%h b=%h want 1 0 %h %h %h",
                 i, alu_valid, cmd_ready, alu_op, alu_a, alu_b, op, e_a, e_b);
      end
    end
    alu_ready = 1'b1;
    tick();
    hs_cycle  = cycle;
    exp_count = (exp_count + 1) % 256;
    checks++;
    if ({alu_valid, cmd_ready, busy, op_count} !== {1'b1 ^ 1'b1, 1'b1, 1'b0, 8'(exp_count)}) begin
      errors++;
      $display("FAIL op_handshake got v=%b rdy=%b busy=%b cnt=%0d want 0 1 0 %0d",
               alu_valid, cmd_ready, busy, op_count, exp_count);
    end
    checks++;
    if ({operand1_addr, operand2_addr} !== {a1, a2}) begin
      errors++;
      $display("FAIL op_addr_hold got %h %h want %h %h", operand1_addr, operand2_addr, a1, a2);
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] ga, gb;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({cmd_ready, busy, alu_valid, operand1_addr, operand2_addr, alu_op, alu_a, alu_b, op_count}
        !== {1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 3'h0, 16'h0, 16'h0, 8'h0}) begin
      errors++;
      $display("FAIL reset_power_on got rdy=%b busy=%b v=%b a1=%h a2=%h op=%h a=%h b=%h cnt=%0d want 1 0 0 0 0 0 0 0 0",
               cmd_ready, busy, alu_valid, operand1_addr, operand2_addr, alu_op, alu_a, alu_b, op_count);
    end
    rst_n = 1'b1;
    tick();
    do_op(3'h5, 4'h7, 4'h9, 0, 0, ga, gb);
    // drive a second op into PRESENT, then reset asynchronously mid-cycle
    cmd_op = 3'h6; cmd_addr1 = 4'hA; cmd_addr2 = 4'hB; cmd_valid = 1'b1; alu_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (alu_valid !== 1'b1) begin
      errors++; $display("FAIL reset_pre_present got v=%b want 1", alu_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_count = 0;
    checks++;
    if ({cmd_ready, busy, alu_valid, operand1_addr, operand2_addr, alu_op, alu_a, alu_b, op_count}
        !== {1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 3'h0, 16'h0, 16'h0, 8'h0}) begin
      errors++;
      $display("FAIL reset_mid_run got rdy=%b busy=%b v=%b a1=%h a2=%h op=%h a=%h b=%h cnt=%0d want 1 0 0 0 0 0 0 0 0",
               cmd_ready, busy, alu_valid, operand1_addr, operand2_addr, alu_op, alu_a, alu_b, op_count);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stalled_alu();
    logic [DW-1:0] ga, gb;
    do_op(3'(($urandom)), 4'(($urandom)), 4'(($urandom)), 10, 0, ga, gb);
    checks++;
    if (op_count !== 8'd1) begin
      errors++; $display("FAIL stall_count got %0d want 1", op_count);
    end
  endtask

  task automatic test_single_op();
    logic [DW-1:0] ga, gb;
    do_op(3'b010, 4'd0, 4'd15, 0, 0, ga, gb);
    checks++;
    if ({ga, gb} !== {16'h4DA3, 16'hD919}) begin
      errors++; $display("FAIL single_operands got a=%h b=%h want a=4da3 b=d919", ga, gb);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] ga, gb;
    int last_hs;
    last_hs = 0;
    for (int k = 1; k <= 4; k++) begin
      do_op(3'(($urandom)), 4'(k), 4'(k), 0, 1, ga, gb);
      if (k > 1) begin
        checks++;
        if (hs_cycle - last_hs != 4) begin
          errors++; $display("FAIL b2b_spacing op%0d got %0d cycles want 4", k, hs_cycle - last_hs);
        end
      end
      last_hs = hs_cycle;
    end
    cmd_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_capture();
    logic [DW-1:0] ga, gb;
    cmd_op = 3'h1; cmd_addr1 = 4'h3; cmd_addr2 = 4'hC; cmd_valid = 1'b1; alu_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if ({busy, alu_valid} !== 2'b10) begin
      errors++; $display("FAIL rstcap_pre got busy=%b v=%b want 1 0", busy, alu_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_count = 0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({alu_valid, cmd_ready, op_count} !== {1'b0, 1'b1, 8'd0}) begin
        errors++;
        $display("FAIL rstcap_idle cyc%0d got v=%b rdy=%b cnt=%0d want 0 1 0", i, alu_valid, cmd_ready, op_count);
      end
    end
    do_op(3'h4, 4'h8, 4'h2, 1, 0, ga, gb);
  endtask

  task automatic test_counter_wrap();
    logic [DW-1:0] ga, gb;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_count = 0;
    tick();
    for (int i = 0; i < 256; i++) begin
      do_op(3'(($urandom)), 4'(($urandom)), 4'(($urandom)), int'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)), ga, gb);
    end
    cmd_valid = 1'b0;
    checks++;
    if (op_count !== 8'd0) begin
      errors++; $display("FAIL wrap_count got %0d want 0", op_count);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem1[i] = 16'($urandom);
      mem2[i] = 16'($urandom);
    end
    mem1[0]  = 16'h4DA3;
    mem2[15] = 16'hD919;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_addr1 = '0;
    cmd_addr2 = '0;
    alu_ready = 1'b0;
    test_reset();
    test_stalled_alu();
    test_single_op();
    test_back_to_back();
    test_reset_capture();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "bench timed out");
  end

endmodule
